// File: rtl/ts_record_pkg.sv
// ts_record_pkg: record type, serializer states and wire-size helper shared by ts_record_serializer.
package ts_record_pkg;
    localparam int ID_W  = 4;
    localparam int TS_W  = 64;
    localparam int SEQ_W = 16;
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] start_ts;
        logic [TS_W-1:0] end_ts;
        logic [TS_W-1:0] delta;
    } ts_rec_t;
    typedef enum logic {IDLE, SEND} ser_state_e;
    // Bytes on the wire for one record: padded id, three timestamps, optional sequence header.
    function automatic int rec_bytes(int id_w, int ts_w, bit seq_en);
        return (id_w + 7) / 8 + 3 * ts_w / 8 + (seq_en ? SEQ_W / 8 : 0);
    endfunction
endpackage

// File: rtl/ts_record_serializer_if.sv
// ts_record_serializer_if: record pulse input and byte-stream output of the serializer.
interface ts_record_serializer_if;
    import ts_record_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [ID_W-1:0] in_id;
    logic [TS_W-1:0] in_start_ts;
    logic [TS_W-1:0] in_end_ts;
    logic [TS_W-1:0] in_ts;
    logic [7:0]      m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    modport slave (
        input  in_valid, in_id, in_start_ts, in_end_ts, in_ts, m_tready,
        output in_ready, m_tdata, m_tvalid, m_tlast
    );
    modport master (
        output in_valid, in_id, in_start_ts, in_end_ts, in_ts, m_tready,
        input  in_ready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/ts_record_fifo.sv
// ts_record_fifo: record FIFO; pushes while full and pops while empty are ignored.
module ts_record_fifo
    import ts_record_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  ts_rec_t                  data_i,
    output ts_rec_t                  data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    ts_rec_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q;
    logic           do_push, do_pop;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign level_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/ts_record_serializer.sv
// ts_record_serializer: buffers timestamp records and emits each as a big-endian byte stream with tlast.
// Define TS_RECORD_SEQ_EN to prepend a 16-bit per-record sequence number.
module ts_record_serializer
    import ts_record_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SLACK      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ts_record_serializer_if.slave         bus,
    output logic [15:0]                   overflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
`ifdef TS_RECORD_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif
    localparam int REC_BYTES = rec_bytes(ID_W, TS_W, SEQ_EN);
    localparam int SR_W      = 8 * REC_BYTES;
    localparam int IDX_W     = $clog2(REC_BYTES);
    ser_state_e       state_q, state_d;
    logic [SR_W-1:0]  sr_q, load_val;
    logic [IDX_W-1:0] idx_q;
    logic             full, empty, pop, hs, last, tvalid;
    ts_rec_t          in_rec, head;
    assign in_rec = {bus.in_id, bus.in_start_ts, bus.in_end_ts, bus.in_ts};
    ts_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(bus.in_valid), .pop_i(pop), .data_i(in_rec),
        .data_o(head), .full_o(full), .empty_o(empty), .level_o(fifo_level)
    );
    // Credit-style ready: upstream may still land SLACK-1 pulses after it deasserts.
    assign bus.in_ready = (FIFO_DEPTH - int'(fifo_level)) >= SLACK;
`ifdef TS_RECORD_SEQ_EN
    logic [SEQ_W-1:0] seq_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seq_q <= '0;
        else if (pop) seq_q <= seq_q + 1'b1;
    end
    assign load_val = {seq_q, 8'(head.id), head.start_ts, head.end_ts, head.delta};
`else
    assign load_val = {8'(head.id), head.start_ts, head.end_ts, head.delta};
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = pop ? SEND : (hs && last) ? IDLE : state_q;
    end
    always_comb begin
        tvalid = state_q == SEND;
        last   = idx_q == IDX_W'(REC_BYTES - 1);
        hs     = tvalid && bus.m_tready;
        pop    = !empty && (state_q == IDLE || (hs && last));
    end
    assign bus.m_tvalid = tvalid;
    assign bus.m_tlast  = tvalid && last;
    assign bus.m_tdata  = sr_q[SR_W-1 -: 8];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else if (pop) begin
            sr_q  <= load_val;
            idx_q <= '0;
        end else if (hs) begin
            sr_q  <= {sr_q[SR_W-9:0], 8'h00};
            idx_q <= idx_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_cnt <= '0;
        else if (bus.in_valid && full && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
    end
endmodule
